// File: rtl/img_hsmooth3.sv
// Horizontal [1 2 1]/4 smoothing of a two-pixels-per-clock RGB stream, fixed 2-cycle latency,
// edge-replicated at row ends, with a per-row bypass latched on the first beat of each row.
//
// state  | meaning
// IDLE   | waiting for the first beat of a row
// ACTIVE | row in progress, col = index of the next expected beat
module img_hsmooth3 #(
    parameter int WIDTH = 768
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       VSYNC_IN,
    input  logic       HSYNC_IN,
    input  logic [7:0] DATA_R0_IN,
    input  logic [7:0] DATA_G0_IN,
    input  logic [7:0] DATA_B0_IN,
    input  logic [7:0] DATA_R1_IN,
    input  logic [7:0] DATA_G1_IN,
    input  logic [7:0] DATA_B1_IN,
    input  logic       en_filter,
    output logic       VSYNC_OUT,
    output logic       HSYNC_OUT,
    output logic [7:0] DATA_R0_OUT,
    output logic [7:0] DATA_G0_OUT,
    output logic [7:0] DATA_B0_OUT,
    output logic [7:0] DATA_R1_OUT,
    output logic [7:0] DATA_G1_OUT,
    output logic [7:0] DATA_B1_OUT,
    output logic       row_err
);
    localparam int BEATS = WIDTH / 2;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col, col_nxt;
    logic            beat_first, beat_last, trunc;

    logic [7:0]      in0 [3];
    logic [7:0]      in1 [3];
    logic [7:0]      s1_p0 [3];
    logic [7:0]      s1_p1 [3];
    logic [7:0]      s1_l [3];
    logic            s1_valid, s1_first, s1_last, s1_byp;
    logic            row_byp;
    logic            vs_d1;

    logic [7:0]      nb_l [3];
    logic [7:0]      nb_r [3];
    logic [9:0]      sum0 [3];
    logic [9:0]      sum1 [3];
    logic [7:0]      f0 [3];
    logic [7:0]      f1 [3];
    logic            use_next;
    logic [7:0]      out0 [3];
    logic [7:0]      out1 [3];

    assign in0[0] = DATA_R0_IN;
    assign in0[1] = DATA_G0_IN;
    assign in0[2] = DATA_B0_IN;
    assign in1[0] = DATA_R1_IN;
    assign in1[1] = DATA_G1_IN;
    assign in1[2] = DATA_B1_IN;

    assign DATA_R0_OUT = out0[0];
    assign DATA_G0_OUT = out0[1];
    assign DATA_B0_OUT = out0[2];
    assign DATA_R1_OUT = out1[0];
    assign DATA_G1_OUT = out1[1];
    assign DATA_B1_OUT = out1[2];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
            col   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        beat_first = 1'b0;
        beat_last  = 1'b0;
        trunc      = 1'b0;
        if (VSYNC_IN) begin
            state_nxt = IDLE;
            col_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (HSYNC_IN) begin
                        beat_first = 1'b1;
                        state_nxt  = ACTIVE;
                        col_nxt    = CW'(1);
                    end
                end
                ACTIVE: begin
                    if (!HSYNC_IN) begin
                        trunc     = 1'b1;
                        state_nxt = IDLE;
                        col_nxt   = '0;
                    end else if (col == CW'(BEATS - 1)) begin
                        beat_last = 1'b1;
                        state_nxt = IDLE;
                        col_nxt   = '0;
                    end else begin
                        col_nxt = col + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    col_nxt   = '0;
                end
            endcase
        end
    end

    // S1: current beat, left neighbour (previous p1) and row-position flags
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_byp   <= 1'b0;
            row_byp  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                s1_p0[i] <= '0;
                s1_p1[i] <= '0;
                s1_l[i]  <= '0;
            end
        end else begin
            s1_valid <= HSYNC_IN;
            if (beat_first)
                row_byp <= ~en_filter;
            if (HSYNC_IN) begin
                s1_first <= beat_first | VSYNC_IN;
                s1_last  <= beat_last | VSYNC_IN;
                s1_byp   <= beat_first ? ~en_filter : row_byp;
                for (int i = 0; i < 3; i++) begin
                    s1_p0[i] <= in0[i];
                    s1_p1[i] <= in1[i];
                    s1_l[i]  <= s1_p1[i];
                end
            end
        end
    end

    // Right neighbour comes from the next beat only when one is actually arriving in this row
    assign use_next = HSYNC_IN & ~VSYNC_IN & ~s1_last;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nb_l[i] = s1_first ? s1_p0[i] : s1_l[i];
            nb_r[i] = use_next ? in0[i] : s1_p1[i];
            sum0[i] = {2'b00, nb_l[i]} + {1'b0, s1_p0[i], 1'b0} + {2'b00, s1_p1[i]} + 10'd2;
            sum1[i] = {2'b00, s1_p0[i]} + {1'b0, s1_p1[i], 1'b0} + {2'b00, nb_r[i]} + 10'd2;
            f0[i]   = s1_byp ? s1_p0[i] : sum0[i][9:2];
            f1[i]   = s1_byp ? s1_p1[i] : sum1[i][9:2];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            vs_d1     <= 1'b0;
            VSYNC_OUT <= 1'b0;
            HSYNC_OUT <= 1'b0;
            row_err   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                out0[i] <= '0;
                out1[i] <= '0;
            end
        end else begin
            vs_d1     <= VSYNC_IN;
            VSYNC_OUT <= vs_d1;
            HSYNC_OUT <= s1_valid;
            if (trunc)
                row_err <= 1'b1;
            if (s1_valid) begin
                for (int i = 0; i < 3; i++) begin
                    out0[i] <= f0[i];
                    out1[i] <= f1[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_img_hsmooth3.sv
// Directed bench for img_hsmooth3 (WIDTH=8): a row-level [1 2 1]/4 model with edge replication
// predicts every output beat; a per-cycle compare process plus literal values pin the model.
module tb_img_hsmooth3;
    localparam int NC = 400;

    logic       HCLK, HRESET, VSYNC_IN, HSYNC_IN, en_filter;
    logic [7:0] DATA_R0_IN, DATA_G0_IN, DATA_B0_IN, DATA_R1_IN, DATA_G1_IN, DATA_B1_IN;
    logic       VSYNC_OUT, HSYNC_OUT, row_err;
    logic [7:0] DATA_R0_OUT, DATA_G0_OUT, DATA_B0_OUT, DATA_R1_OUT, DATA_G1_OUT, DATA_B1_OUT;

    img_hsmooth3 #(.WIDTH(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .VSYNC_IN(VSYNC_IN), .HSYNC_IN(HSYNC_IN),
        .DATA_R0_IN(DATA_R0_IN), .DATA_G0_IN(DATA_G0_IN), .DATA_B0_IN(DATA_B0_IN),
        .DATA_R1_IN(DATA_R1_IN), .DATA_G1_IN(DATA_G1_IN), .DATA_B1_IN(DATA_B1_IN),
        .en_filter(en_filter),
        .VSYNC_OUT(VSYNC_OUT), .HSYNC_OUT(HSYNC_OUT),
        .DATA_R0_OUT(DATA_R0_OUT), .DATA_G0_OUT(DATA_G0_OUT), .DATA_B0_OUT(DATA_B0_OUT),
        .DATA_R1_OUT(DATA_R1_OUT), .DATA_G1_OUT(DATA_G1_OUT), .DATA_B1_OUT(DATA_B1_OUT),
        .row_err(row_err)
    );

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    bit run_chk = 0;
    bit exp_hs [NC];
    bit exp_vs [NC];
    int exp_d [NC][6];
    int cap_r0 [NC];
    int cap_r1 [NC];

    initial HCLK = 0;
    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Channel derivation so that channel swaps are visible: R=v, G=v/2, B=255-v
    function automatic int chv(input int v, input int ch);
        if (ch == 0) return v;
        if (ch == 1) return v >> 1;
        return 255 - v;
    endfunction

    function automatic int smooth(input int a[8], input int npix, input int x, input bit byp);
        int l, r;
        l = (x == 0) ? a[0] : a[x-1];
        r = (x == npix - 1) ? a[x] : a[x+1];
        return byp ? a[x] : (l + 2 * a[x] + r + 2) >> 2;
    endfunction

    always @(negedge HCLK) begin
        if (cyc < NC) begin
            cap_r0[cyc] = DATA_R0_OUT;
            cap_r1[cyc] = DATA_R1_OUT;
            if (run_chk) begin
                chk("hsync_out", HSYNC_OUT, exp_hs[cyc]);
                chk("vsync_out", VSYNC_OUT, exp_vs[cyc]);
                if (exp_hs[cyc]) begin
                    chk("r0", DATA_R0_OUT, exp_d[cyc][0]);
                    chk("g0", DATA_G0_OUT, exp_d[cyc][1]);
                    chk("b0", DATA_B0_OUT, exp_d[cyc][2]);
                    chk("r1", DATA_R1_OUT, exp_d[cyc][3]);
                    chk("g1", DATA_G1_OUT, exp_d[cyc][4]);
                    chk("b1", DATA_B1_OUT, exp_d[cyc][5]);
                end
            end
        end
    end

    // Presents nb beats starting at the current negedge; rst_beat >= 0 asserts HRESET on that beat.
    task automatic send_row(input int vals[8], input int nb, input bit en, input bit toggle,
                            input int rst_beat, output int c0);
        int npix;
        int a[8];
        c0 = cyc;
        npix = (rst_beat >= 0) ? 8 : 2 * nb;
        for (int ch = 0; ch < 3; ch++) begin
            for (int x = 0; x < 8; x++) a[x] = chv(vals[x], ch);
            for (int k = 0; k < nb; k++) begin
                if ((rst_beat < 0 || k + 2 <= rst_beat) && c0 + k + 2 < NC) begin
                    exp_hs[c0+k+2] = 1'b1;
                    exp_d[c0+k+2][ch]   = smooth(a, npix, 2 * k, ~en);
                    exp_d[c0+k+2][ch+3] = smooth(a, npix, 2 * k + 1, ~en);
                end
            end
        end
        for (int k = 0; k < nb; k++) begin
            HSYNC_IN   = 1'b1;
            HRESET     = (k == rst_beat);
            en_filter  = (toggle && k > 0) ? ~en : en;
            DATA_R0_IN = 8'(chv(vals[2*k], 0));
            DATA_G0_IN = 8'(chv(vals[2*k], 1));
            DATA_B0_IN = 8'(chv(vals[2*k], 2));
            DATA_R1_IN = 8'(chv(vals[2*k+1], 0));
            DATA_G1_IN = 8'(chv(vals[2*k+1], 1));
            DATA_B1_IN = 8'(chv(vals[2*k+1], 2));
            @(negedge HCLK);
        end
    endtask

    task automatic idle(input int n);
        HSYNC_IN = 1'b0;
        HRESET   = 1'b0;
        VSYNC_IN = 1'b0;
        repeat (n) @(negedge HCLK);
    endtask

    task automatic vpulse();
        VSYNC_IN = 1'b1;
        if (cyc + 2 < NC) exp_vs[cyc+2] = 1'b1;
        @(negedge HCLK);
        VSYNC_IN = 1'b0;
    endtask

    initial begin
        int flat[8]  = '{100, 100, 100, 100, 100, 100, 100, 100};
        int imp[8]   = '{0, 0, 0, 200, 0, 0, 0, 0};
        int ramp[8]  = '{0, 4, 8, 12, 16, 20, 24, 28};
        int trn[8]   = '{10, 20, 30, 40, 0, 0, 0, 0};
        int c_flat, c_ramp, c_imp, c_byp, c_imp2, c_trn, c_flat2, c_rst, c_flat3;

        HRESET = 1; VSYNC_IN = 0; HSYNC_IN = 0; en_filter = 1;
        DATA_R0_IN = 0; DATA_G0_IN = 0; DATA_B0_IN = 0;
        DATA_R1_IN = 0; DATA_G1_IN = 0; DATA_B1_IN = 0;
        repeat (3) @(negedge HCLK);
        chk("reset_hsync", HSYNC_OUT, 0);
        chk("reset_vsync", VSYNC_OUT, 0);
        chk("reset_r0", DATA_R0_OUT, 0);
        chk("reset_b1", DATA_B1_OUT, 0);
        chk("reset_row_err", row_err, 0);
        run_chk = 1;
        idle(2);

        // flat row, then a ramp row starting on the very next cycle
        send_row(flat, 4, 1'b1, 1'b0, -1, c_flat);
        send_row(ramp, 4, 1'b1, 1'b0, -1, c_ramp);
        idle(3);
        chk("flat_x0", cap_r0[c_flat+2], 100);
        chk("flat_x7", cap_r1[c_flat+5], 100);
        chk("ramp_x0", cap_r0[c_ramp+2], 1);
        chk("ramp_x3", cap_r1[c_ramp+3], 12);
        chk("ramp_x7", cap_r1[c_ramp+5], 27);

        send_row(imp, 4, 1'b1, 1'b0, -1, c_imp);
        idle(3);
        chk("imp_x1", cap_r1[c_imp+2], 0);
        chk("imp_x2", cap_r0[c_imp+3], 50);
        chk("imp_x3", cap_r1[c_imp+3], 100);
        chk("imp_x4", cap_r0[c_imp+4], 50);

        // bypass row with en_filter toggled mid-row, then a filtered row toggled the other way
        send_row(imp, 4, 1'b0, 1'b1, -1, c_byp);
        send_row(imp, 4, 1'b1, 1'b1, -1, c_imp2);
        idle(3);
        chk("byp_x3", cap_r1[c_byp+3], 200);
        chk("byp_x2", cap_r0[c_byp+3], 0);
        chk("imp2_x3", cap_r1[c_imp2+3], 100);
        chk("row_err_clean", row_err, 0);

        vpulse();
        idle(3);

        // two-beat row: the formula gives 13,20,30,38
        send_row(trn, 2, 1'b1, 1'b0, -1, c_trn);
        idle(3);
        chk("trn_x0", cap_r0[c_trn+2], 13);
        chk("trn_x1", cap_r1[c_trn+2], 20);
        chk("trn_x2", cap_r0[c_trn+3], 30);
        chk("trn_x3", cap_r1[c_trn+3], 38);
        chk("row_err_set", row_err, 1);
        send_row(flat, 4, 1'b1, 1'b0, -1, c_flat2);
        idle(3);
        chk("flat2_x0", cap_r0[c_flat2+2], 100);
        chk("row_err_sticky", row_err, 1);

        // reset asserted during beat 2 of a ramp row
        send_row(ramp, 3, 1'b1, 1'b0, 2, c_rst);
        chk("rst_hsync", HSYNC_OUT, 0);
        chk("rst_r0", DATA_R0_OUT, 0);
        chk("rst_g1", DATA_G1_OUT, 0);
        chk("rst_row_err", row_err, 0);
        idle(3);
        send_row(flat, 4, 1'b1, 1'b0, -1, c_flat3);
        idle(4);
        chk("flat3_x0", cap_r0[c_flat3+2], 100);
        chk("flat3_x7", cap_r1[c_flat3+5], 100);

        run_chk = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
